alu_flag_wb_stage: RTL



---
 rtl/alu_flag_wb_stage_if.sv | 50 +++++
 rtl/alu_flag_wb_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_flag_wb_stage_if.sv
// Handshake bundle between the ALU-side driver, this stage and the register-file writeback port.
// The master drives instructions in and accepts writebacks; the slave is the stage itself.
interface alu_flag_wb_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] alu_r;
   logic [3:0]  alu_flag;
   logic [4:0]  alu_op;
   logic        s_bit;
   logic [3:0]  cond;
   logic [3:0]  rd;
   logic        sh_cout;

   logic        wb_valid;
   logic        wb_ready;
   logic [31:0] wb_data;
   logic [3:0]  wb_rd;

   modport master (
      output in_valid,
      output alu_r,
      output alu_flag,
      output alu_op,
      output s_bit,
      output cond,
      output rd,
      output sh_cout,
      input  in_ready,
      output wb_ready,
      input  wb_valid,
      input  wb_data,
      input  wb_rd
   );

   modport slave (
      input  in_valid,
      input  alu_r,
      input  alu_flag,
      input  alu_op,
      input  s_bit,
      input  cond,
      input  rd,
      input  sh_cout,
      output in_ready,
      input  wb_ready,
      output wb_valid,
      output wb_data,
      output wb_rd
   );
endinterface

// File: rtl/alu_flag_wb_stage.sv
// Post-ALU stage: evaluates the condition field against committed NZCV, commits flags by opcode
// class, and queues surviving register writes in a two-entry in-order buffer.
module alu_flag_wb_stage (
   input  logic                 clk,
   input  logic                 reset,
   alu_flag_wb_stage_if.slave   bus,
   output logic [3:0]           cpsr_flag,
   output logic                 cin,
   output logic [7:0]           skip_cnt
);

   localparam logic [1:0] DEPTH = 2'd2;

   typedef enum logic [2:0] {
      CLS_NONE,
      CLS_ARITH,
      CLS_LOGIC,
      CLS_TEST,
      CLS_COMPARE,
      CLS_ADDR
   } op_class_t;

   op_class_t   op_class;
   logic        cond_pass;
   logic        accept;
   logic        push;
   logic        pop;
   logic [3:0]  flag_next;
   logic [1:0]  count;
   logic [1:0]  count_next;
   logic        in_ready_q;
   logic [35:0] entry [2];
   logic [35:0] new_entry;

   logic flag_n;
   logic flag_z;
   logic flag_c;
   logic flag_v;

   assign flag_c = cpsr_flag[3];
   assign flag_z = cpsr_flag[2];
   assign flag_v = cpsr_flag[1];
   assign flag_n = cpsr_flag[0];

   assign accept       = bus.in_valid & in_ready_q;
   assign bus.in_ready = in_ready_q;
   assign cin          = cpsr_flag[3];

   always_comb begin
      op_class = CLS_NONE;
      unique case (bus.alu_op)
         5'b00010, 5'b00011, 5'b00100,
         5'b00101, 5'b00110, 5'b00111: op_class = CLS_ARITH;
         5'b00000, 5'b00001, 5'b01100,
         5'b01101, 5'b01110, 5'b01111: op_class = CLS_LOGIC;
         5'b01000, 5'b01001:           op_class = CLS_TEST;
         5'b01010, 5'b01011:           op_class = CLS_COMPARE;
         5'b10000, 5'b10001, 5'b10010,
         5'b10011, 5'b10100, 5'b10101,
         5'b10110, 5'b10111, 5'b11000,
         5'b11001, 5'b11010:           op_class = CLS_ADDR;
         default:                      op_class = CLS_NONE;
      endcase
   end

   always_comb begin
      cond_pass = 1'b0;
      unique case (bus.cond)
         4'd0:  cond_pass = flag_z;
         4'd1:  cond_pass = ~flag_z;
         4'd2:  cond_pass = flag_c;
         4'd3:  cond_pass = ~flag_c;
         4'd4:  cond_pass = flag_n;
         4'd5:  cond_pass = ~flag_n;
         4'd6:  cond_pass = flag_v;
         4'd7:  cond_pass = ~flag_v;
         4'd8:  cond_pass = flag_c & ~flag_z;
         4'd9:  cond_pass = ~flag_c | flag_z;
         4'd10: cond_pass = (flag_n == flag_v);
         4'd11: cond_pass = (flag_n != flag_v);
         4'd12: cond_pass = ~flag_z & (flag_n == flag_v);
         4'd13: cond_pass = flag_z | (flag_n != flag_v);
         4'd14: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Logical and test ops take C from the shifter and leave V alone; arithmetic and compares take all four.
   always_comb begin
      flag_next = cpsr_flag;
      push      = 1'b0;
      if (accept && cond_pass) begin
         unique case (op_class)
            CLS_ARITH: begin
               if (bus.s_bit) flag_next = bus.alu_flag;
               push = 1'b1;
            end
            CLS_LOGIC: begin
               if (bus.s_bit) flag_next = {bus.sh_cout, bus.alu_flag[2], flag_v, bus.alu_flag[0]};
               push = 1'b1;
            end
            CLS_TEST: begin
               flag_next = {bus.sh_cout, bus.alu_flag[2], flag_v, bus.alu_flag[0]};
            end
            CLS_COMPARE: begin
               flag_next = bus.alu_flag;
            end
            CLS_ADDR: begin
               push = 1'b1;
            end
            default: begin
               push = 1'b0;
            end
         endcase
      end
   end

   assign new_entry    = {bus.alu_r, bus.rd};
   assign pop          = bus.wb_valid & bus.wb_ready;
   assign count_next   = count + {1'b0, push} - {1'b0, pop};
   assign bus.wb_valid = (count != 2'd0);
   assign bus.wb_data  = entry[0][35:4];
   assign bus.wb_rd    = entry[0][3:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cpsr_flag <= 4'b0000;
         skip_cnt  <= 8'd0;
      end else begin
         cpsr_flag <= flag_next;
         if (accept && !cond_pass && skip_cnt != 8'hFF) skip_cnt <= skip_cnt + 8'd1;
      end
   end

   // entry[0] is always the head; a simultaneous push and pop at count 1 lands the new entry at the head.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= 2'd0;
         in_ready_q <= 1'b1;
         entry[0]   <= '0;
         entry[1]   <= '0;
      end else begin
         count      <= count_next;
         in_ready_q <= (count_next < DEPTH);
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) entry[0] <= new_entry;
               else               entry[1] <= new_entry;
            end
            2'b01: begin
               entry[0] <= entry[1];
            end
            2'b11: begin
               if (count == 2'd1) begin
                  entry[0] <= new_entry;
               end else begin
                  entry[0] <= entry[1];
                  entry[1] <= new_entry;
               end
            end
            default: begin
               entry[0] <= entry[0];
            end
         endcase
      end
   end

endmodule
